// File: rtl/umul_pkg.sv
// Shared definitions for the 4x4 multiplier datapath and its accumulator.
package umul_pkg;

  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    EMIT_HI = 2'd1,
    EMIT_LO = 2'd2
  } state_t;

  function automatic logic [15:0] zext_prod(
    input logic [PROD_W-1:0] p
  );
    return 16'(p);
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: clamps to all-ones on carry out.
module sat_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] wide;

  assign wide = {1'b0, a} + {1'b0, b};
  assign sat  = wide[ACC_W];
  assign sum  = sat ? '1 : wide[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of multiplier products with saturation and
// streams each block sum out as a high byte then a low byte.
module product_accumulator
  import umul_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [7:0]        out,
  output logic              out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] nxt;
  logic [7:0]       count;
  logic             ovf_int;
  logic             sat;
  logic [15:0]      pz;
  logic             hs;

  function automatic logic [7:0] hi_byte(
    input logic [ACC_W-1:0] s
  );
    logic [15:0] w;
    w = 16'(s);
    return w[15:8];
  endfunction

  assign pz         = zext_prod(prod_in);
  assign prod_ready = (state == ACCUM) && !clear;
  assign hs         = prod_valid && prod_ready;

  sat_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .a  (acc),
    .b  (pz[ACC_W-1:0]),
    .sum(nxt),
    .sat(sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      sum       <= '0;
      count     <= '0;
      ovf_int   <= 1'b0;
      out       <= '0;
      out_sel   <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (clear) begin
            acc     <= '0;
            count   <= '0;
            ovf_int <= 1'b0;
          end else if (hs) begin
            acc     <= nxt;
            ovf_int <= ovf_int | sat;
            if (count == LAST) begin
              // High byte is loaded straight from the adder
              sum       <= nxt;
              count     <= '0;
              out       <= hi_byte(nxt);
              out_sel   <= 1'b1;
              out_valid <= 1'b1;
              ovf       <= ovf_int | sat;
              state     <= EMIT_HI;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        EMIT_HI: begin
          if (out_ready) begin
            out     <= sum[7:0];
            out_sel <= 1'b0;
            state   <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
            ovf_int   <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (default and 10-bit/8-deep).
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] a_prod  = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic       a_clear = 1'b0;
  logic [7:0] a_out;
  logic       a_sel;
  logic       a_ovalid;
  logic       a_oready = 1'b1;
  logic       a_ovf;

  logic [7:0] b_prod  = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       b_clear = 1'b0;
  logic [7:0] b_out;
  logic       b_sel;
  logic       b_ovalid;
  logic       b_oready = 1'b1;
  logic       b_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator dut_a (
    .clk       (clk),
    .rst       (rst),
    .prod_in   (a_prod),
    .prod_valid(a_valid),
    .prod_ready(a_ready),
    .clear     (a_clear),
    .out       (a_out),
    .out_sel   (a_sel),
    .out_valid (a_ovalid),
    .out_ready (a_oready),
    .ovf       (a_ovf)
  );

  product_accumulator #(
    .ACC_W    (10),
    .BLOCK_LEN(8)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .prod_in   (b_prod),
    .prod_valid(b_valid),
    .prod_ready(b_ready),
    .clear     (b_clear),
    .out       (b_out),
    .out_sel   (b_sel),
    .out_valid (b_ovalid),
    .out_ready (b_oready),
    .ovf       (b_ovf)
  );

  task automatic send_a(input logic [7:0] p);
    a_prod  = p;
    a_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !a_ready; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_a: prod_ready=%b required 1", a_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    b_prod  = p;
    b_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !b_ready; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_b: prod_ready=%b required 1", b_ready);
    end
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic recv_a(input logic [7:0] eo, input logic es,
                        input logic ev, input string nm);
    for (int i = 0; i < 20 && !a_ovalid; i++) @(negedge clk);
    checks++;
    if ({a_ovalid, a_out, a_sel, a_ovf} !== {1'b1, eo, es, ev}) begin
      errors++;
      $display("FAIL %s: valid=%b out=%h sel=%b ovf=%b required 1 %h %b %b",
               nm, a_ovalid, a_out, a_sel, a_ovf, eo, es, ev);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic recv_b(input logic [7:0] eo, input logic es,
                        input logic ev, input string nm);
    for (int i = 0; i < 20 && !b_ovalid; i++) @(negedge clk);
    checks++;
    if ({b_ovalid, b_out, b_sel, b_ovf} !== {1'b1, eo, es, ev}) begin
      errors++;
      $display("FAIL %s: valid=%b out=%h sel=%b ovf=%b required 1 %h %b %b",
               nm, b_ovalid, b_out, b_sel, b_ovf, eo, es, ev);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({a_ovalid, a_out, a_sel, a_ovf, a_ready} !== 12'b0_00000000_0_0_1) begin
      errors++;
      $display("FAIL reset_a: v=%b out=%h sel=%b ovf=%b rdy=%b required 0 00 0 0 1",
               a_ovalid, a_out, a_sel, a_ovf, a_ready);
    end
    checks++;
    if ({b_ovalid, b_out, b_sel, b_ovf, b_ready} !== 12'b0_00000000_0_0_1) begin
      errors++;
      $display("FAIL reset_b: v=%b out=%h sel=%b ovf=%b rdy=%b required 0 00 0 0 1",
               b_ovalid, b_out, b_sel, b_ovf, b_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) send_a(8'd225);
    checks++;
    if (a_ovalid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b required 1", a_ovalid);
    end
    recv_a(8'h03, 1'b1, 1'b0, "basic_hi");
    recv_a(8'h84, 1'b0, 1'b0, "basic_lo");
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop: out_valid=%b required 0", a_ovalid);
    end
  endtask

  task automatic test_backpressure();
    a_oready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(8'd225);
    a_prod  = 8'd7;
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({a_ovalid, a_out, a_sel, a_ready} !== {1'b1, 8'h03, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: v=%b out=%h sel=%b rdy=%b required 1 03 1 0",
                 a_ovalid, a_out, a_sel, a_ready);
      end
      @(negedge clk);
    end
    a_valid  = 1'b0;
    a_oready = 1'b1;
    recv_a(8'h03, 1'b1, 1'b0, "stall_hi");
    recv_a(8'h84, 1'b0, 1'b0, "stall_lo");
    for (int i = 0; i < 4; i++) send_a(8'd1);
    recv_a(8'h00, 1'b1, 1'b0, "stall_next_hi");
    recv_a(8'h04, 1'b0, 1'b0, "stall_next_lo");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) send_b(8'd225);
    recv_b(8'h03, 1'b1, 1'b1, "sat_hi");
    recv_b(8'hFF, 1'b0, 1'b1, "sat_lo");
    for (int i = 0; i < 8; i++) send_b(8'd1);
    recv_b(8'h00, 1'b1, 1'b0, "sat_next_hi");
    recv_b(8'h08, 1'b0, 1'b0, "sat_next_lo");
  endtask

  task automatic test_clear();
    send_a(8'd10);
    send_a(8'd20);
    a_clear = 1'b1;
    a_prod  = 8'd99;
    a_valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready: prod_ready=%b required 0", a_ready);
    end
    @(negedge clk);
    a_clear = 1'b0;
    a_valid = 1'b0;
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    send_a(8'd4);
    recv_a(8'h00, 1'b1, 1'b0, "clear_hi");
    recv_a(8'h0A, 1'b0, 1'b0, "clear_lo");
  endtask

  task automatic test_idle_gaps();
    send_a(8'd0);
    @(negedge clk);
    send_a(8'd0);
    @(negedge clk);
    send_a(8'd0);
    @(negedge clk);
    send_a(8'd1);
    recv_a(8'h00, 1'b1, 1'b0, "gaps_hi");
    recv_a(8'h01, 1'b0, 1'b0, "gaps_lo");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) send_a(8'd1);
    @(posedge clk);
    @(negedge clk);
    a_oready = 1'b0;
    checks++;
    if ({a_ovalid, a_sel} !== 2'b10) begin
      errors++;
      $display("FAIL rst_pre: valid=%b sel=%b required 1 0", a_ovalid, a_sel);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b required 0", a_ovalid);
    end
    @(negedge clk);
    rst      = 1'b0;
    a_oready = 1'b1;
    #1;
    checks++;
    if ({a_ovalid, a_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_release: valid=%b rdy=%b required 0 1", a_ovalid, a_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_a(8'd1);
    recv_a(8'h00, 1'b1, 1'b0, "rst_next_hi");
    recv_a(8'h04, 1'b0, 1'b0, "rst_next_lo");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_clear();
    test_idle_gaps();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
